// File: rtl/led_mmio_ctrl_if.sv
// CPU data-bus port of the LED peripheral: store/load strobes, address, data and read response.
// The master side is the core; the slave side is led_mmio_ctrl.
interface led_mmio_ctrl_if;
  logic        i_we;
  logic        i_re;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_wstrb;
  logic [31:0] o_rdata;
  logic        o_rvalid;

  modport master (
    output i_we, i_re, i_addr, i_wdata, i_wstrb,
    input  o_rdata, o_rvalid
  );

  modport slave (
    input  i_we, i_re, i_addr, i_wdata, i_wstrb,
    output o_rdata, o_rvalid
  );
endinterface

// File: rtl/led_mmio_ctrl.sv
// Memory-mapped LED peripheral: static LED data, per-LED hardware blink and register read-back.
// Optional PWM dimming register at offset 0x10 is built only when LED_PWM_EN is defined.
module led_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
  parameter int          NUM_LED    = 6,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  led_mmio_ctrl_if.slave     i_bus,
  output logic [NUM_LED-1:0] o_led
);

`ifdef LED_PWM_EN
  localparam int WIN_WORDS = 5;
`else
  localparam int WIN_WORDS = 4;
`endif
  localparam logic [NUM_LED-1:0] LED_OFF = {NUM_LED{ACTIVE_LOW}};

  logic [NUM_LED-1:0] r_ledData;
  logic [NUM_LED-1:0] r_blinkMask;
  logic [23:0]        r_blinkDiv;
  logic [23:0]        r_cnt;
  logic               r_phase;
  logic [NUM_LED-1:0] r_led;
  logic [31:0]        r_rdata;
  logic               r_rvalid;

  logic [31:0]        w_off;
  logic               w_hit;
  logic [2:0]         w_idx;
  logic               w_wrEn;
  logic               w_divWr;
  logic [31:0]        w_byteMask;
  logic [NUM_LED-1:0] w_ledNew;
  logic [NUM_LED-1:0] w_maskNew;
  logic [23:0]        w_divNew;
  logic [31:0]        w_rdMux;
  logic [NUM_LED-1:0] w_lit;
  logic               w_unused;

  // Word offset from the window base; addresses below BASE wrap high and miss the window.
  assign w_off  = {i_bus.i_addr[31:2], 2'b00} - BASE_ADDR;
  assign w_hit  = (w_off[31:2] < 30'(WIN_WORDS));
  assign w_idx  = w_off[4:2];
  assign w_wrEn = i_bus.i_we & w_hit & (|i_bus.i_wstrb);
  assign w_divWr = w_wrEn & (w_idx == 3'd2);

  assign w_byteMask = {{8{i_bus.i_wstrb[3]}}, {8{i_bus.i_wstrb[2]}},
                       {8{i_bus.i_wstrb[1]}}, {8{i_bus.i_wstrb[0]}}};
  assign w_ledNew  = (r_ledData & ~w_byteMask[NUM_LED-1:0]) |
                     (i_bus.i_wdata[NUM_LED-1:0] & w_byteMask[NUM_LED-1:0]);
  assign w_maskNew = (r_blinkMask & ~w_byteMask[NUM_LED-1:0]) |
                     (i_bus.i_wdata[NUM_LED-1:0] & w_byteMask[NUM_LED-1:0]);
  assign w_divNew  = (r_blinkDiv & ~w_byteMask[23:0]) | (i_bus.i_wdata[23:0] & w_byteMask[23:0]);

  assign w_unused = ^{i_bus.i_addr[1:0], w_off[1:0], w_byteMask[31:24], i_bus.i_wdata[31:24]};

`ifdef LED_PWM_EN
  logic [7:0] r_pwmDuty;
  logic [7:0] r_pwmCnt;
  logic [7:0] w_dutyNew;
  logic       w_pwmOn;

  assign w_dutyNew = (r_pwmDuty & ~w_byteMask[7:0]) | (i_bus.i_wdata[7:0] & w_byteMask[7:0]);
  assign w_pwmOn   = (r_pwmDuty == 8'hFF) | (r_pwmCnt < r_pwmDuty);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwmDuty <= 8'hFF;
      r_pwmCnt  <= 8'd0;
    end else begin
      r_pwmCnt <= r_pwmCnt + 8'd1;
      if (w_wrEn && (w_idx == 3'd4)) r_pwmDuty <= w_dutyNew;
    end
  end

  assign w_lit = r_ledData & ~(r_blinkMask & {NUM_LED{r_phase}}) & {NUM_LED{w_pwmOn}};
`else
  assign w_lit = r_ledData & ~(r_blinkMask & {NUM_LED{r_phase}});
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ledData   <= '0;
      r_blinkMask <= '0;
      r_blinkDiv  <= '0;
    end else if (w_wrEn) begin
      if (w_idx == 3'd0) r_ledData   <= w_ledNew;
      if (w_idx == 3'd1) r_blinkMask <= w_maskNew;
      if (w_idx == 3'd2) r_blinkDiv  <= w_divNew;
    end
  end

  // A divider write restarts the half-period from zero so the new rate starts cleanly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_divWr || (r_blinkDiv == 24'd0)) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == r_blinkDiv) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + 24'd1;
    end
  end

  always_comb begin
    w_rdMux = '0;
    if (w_hit) begin
      case (w_idx)
        3'd0: w_rdMux[NUM_LED-1:0] = r_ledData;
        3'd1: w_rdMux[NUM_LED-1:0] = r_blinkMask;
        3'd2: w_rdMux[23:0]        = r_blinkDiv;
        3'd3: w_rdMux[0]           = r_phase;
`ifdef LED_PWM_EN
        3'd4: w_rdMux[7:0]         = r_pwmDuty;
`endif
        default: w_rdMux = '0;
      endcase
    end
  end

  // Read data is captured from pre-edge register values, so a same-cycle store reads old.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_led    <= LED_OFF;
    end else begin
      r_rvalid <= i_bus.i_re;
      if (i_bus.i_re) r_rdata <= w_rdMux;
      r_led <= ACTIVE_LOW ? ~w_lit : w_lit;
    end
  end

  assign i_bus.o_rdata  = r_rdata;
  assign i_bus.o_rvalid = r_rvalid;
  assign o_led          = r_led;

endmodule

// File: tb/tb_led_mmio_ctrl.sv
// Self-checking bench for led_mmio_ctrl: directed literal checks plus randomized bus traffic
// compared every cycle against a cycle-count based behavioural model.
module tb_led_mmio_ctrl;
  localparam logic [31:0] BASE    = 32'h0000_0100;
  localparam int          NL      = 6;
  localparam bit          AL      = 1'b1;
  localparam logic [5:0]  LED_OFF = AL ? 6'h3F : 6'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] o_led;
  int         nChecks = 0;
  int         nErrors = 0;

  led_mmio_ctrl_if bus();

  led_mmio_ctrl #(.BASE_ADDR(BASE), .NUM_LED(NL), .ACTIVE_LOW(AL)) dut (
    .clk   (clk),
    .reset (reset),
    .i_bus (bus),
    .o_led (o_led)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: blink phase derives from edges elapsed since the last restart.
  logic [5:0]  mLed, mMask;
  logic [23:0] mDiv;
  logic [7:0]  mDuty;
  longint      mElapsed, mCycles;
  logic [5:0]  expLed = 6'h3F;
  logic        expRvalid = 1'b0;
  logic [31:0] expRdata = 32'h0;

  function automatic logic mPhase();
    if (mDiv == 24'd0) return 1'b0;
    return ((mElapsed / (longint'(mDiv) + 1)) % 2) == 1;
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] readModel(input logic [31:0] a);
    logic [31:0] off;
    off = {a[31:2], 2'b00} - BASE;
    case (off)
      32'h00: return {26'd0, mLed};
      32'h04: return {26'd0, mMask};
      32'h08: return {8'd0, mDiv};
      32'h0C: return {31'd0, mPhase()};
`ifdef LED_PWM_EN
      32'h10: return {24'd0, mDuty};
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [5:0] modelLit();
    logic [5:0] lit;
    lit = mLed & ~(mMask & {6{mPhase()}});
`ifdef LED_PWM_EN
    if (!((mDuty == 8'hFF) || ((mCycles % 256) < longint'(mDuty)))) lit = 6'h00;
`endif
    return lit;
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [31:0] off, tmp;
    logic        divWr;
    logic [23:0] oldDiv;
    if (!reset) begin
      mLed = 0; mMask = 0; mDiv = 0; mDuty = 8'hFF; mElapsed = 0; mCycles = 0;
      expLed = LED_OFF; expRvalid = 1'b0; expRdata = 32'h0;
    end else begin
      expLed    = AL ? ~modelLit() : modelLit();
      expRvalid = bus.i_re;
      if (bus.i_re) expRdata = readModel(bus.i_addr);
      oldDiv = mDiv;
      divWr  = 1'b0;
      if (bus.i_we && (bus.i_wstrb != 4'h0)) begin
        off = {bus.i_addr[31:2], 2'b00} - BASE;
        case (off)
          32'h00: begin tmp = mergeBytes({26'd0, mLed}, bus.i_wdata, bus.i_wstrb); mLed = tmp[5:0]; end
          32'h04: begin tmp = mergeBytes({26'd0, mMask}, bus.i_wdata, bus.i_wstrb); mMask = tmp[5:0]; end
          32'h08: begin tmp = mergeBytes({8'd0, mDiv}, bus.i_wdata, bus.i_wstrb); mDiv = tmp[23:0]; divWr = 1'b1; end
`ifdef LED_PWM_EN
          32'h10: begin tmp = mergeBytes({24'd0, mDuty}, bus.i_wdata, bus.i_wstrb); mDuty = tmp[7:0]; end
`endif
          default: ;
        endcase
      end
      if (divWr || (oldDiv == 24'd0)) mElapsed = 0;
      else mElapsed++;
      mCycles++;
    end
  end

  // Every-cycle compare, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    checkOutput("model o_led", {26'd0, o_led}, {26'd0, expLed});
    checkOutput("model o_rvalid", {31'd0, bus.o_rvalid}, {31'd0, expRvalid});
    checkOutput("model o_rdata", bus.o_rdata, expRdata);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Drive one bus cycle starting just after a falling edge; returns after the sampling edge.
  task automatic applyStimulus(input logic we, input logic re, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.i_we = we; bus.i_re = re; bus.i_addr = addr; bus.i_wdata = wdata; bus.i_wstrb = wstrb;
    @(negedge clk);
    #1;
    bus.i_we = 1'b0; bus.i_re = 1'b0; bus.i_addr = 32'h0; bus.i_wdata = 32'h0; bus.i_wstrb = 4'h0;
  endtask

  initial begin
    int sel;
    int litCnt;
    logic [31:0] addr, wdata;
    bus.i_we = 1'b0; bus.i_re = 1'b0; bus.i_addr = 32'h0; bus.i_wdata = 32'h0; bus.i_wstrb = 4'h0;
    reset = 1'b1;
    #1 reset = 1'b0;
    idle(3);
    checkOutput("reset o_led", {26'd0, o_led}, 32'h3F);
    checkOutput("reset o_rvalid", {31'd0, bus.o_rvalid}, 32'h0);
    reset = 1'b1;
    idle(3);
    checkOutput("idle o_led", {26'd0, o_led}, 32'h3F);

    applyStimulus(1, 0, BASE, 32'h15, 4'hF);
    idle(1);
    checkOutput("static o_led", {26'd0, o_led}, 32'h2A);
    applyStimulus(0, 1, BASE, 0, 0);
    checkOutput("static rvalid", {31'd0, bus.o_rvalid}, 32'h1);
    checkOutput("static rdata", bus.o_rdata, 32'h15);

    applyStimulus(1, 0, BASE, 32'hFFFF_FFFF, 4'h0);
    applyStimulus(0, 1, BASE, 0, 0);
    checkOutput("wstrb0 rdata", bus.o_rdata, 32'h15);
    applyStimulus(0, 1, 32'h200, 0, 0);
    checkOutput("oow rvalid", {31'd0, bus.o_rvalid}, 32'h1);
    checkOutput("oow rdata", bus.o_rdata, 32'h0);
    applyStimulus(1, 1, BASE, 32'h07, 4'hF);
    checkOutput("read-old rdata", bus.o_rdata, 32'h15);
    applyStimulus(0, 1, BASE, 0, 0);
    checkOutput("reread rdata", bus.o_rdata, 32'h07);
    idle(1);
    checkOutput("rdata hold", bus.o_rdata, 32'h07);

    applyStimulus(1, 0, BASE, 32'h3F, 4'hF);
    applyStimulus(1, 0, BASE + 4, 32'h01, 4'hF);
    applyStimulus(1, 0, BASE + 8, 32'h03, 4'hF);
    for (int i = 0; i < 16; i++) begin
      idle(1);
      checkOutput("blink o_led", {26'd0, o_led}, 32'((i / 4) % 2));
    end

    applyStimulus(1, 0, BASE + 8, 32'd10, 4'hF);
    idle(5);
    reset = 1'b0;
    #1;
    checkOutput("async reset o_led", {26'd0, o_led}, 32'h3F);
    checkOutput("async reset rvalid", {31'd0, bus.o_rvalid}, 32'h0);
    idle(2);
    reset = 1'b1;
    idle(1);
    applyStimulus(0, 1, BASE, 0, 0);
    checkOutput("post-reset LED_DATA", bus.o_rdata, 32'h0);
    applyStimulus(0, 1, BASE + 4, 0, 0);
    checkOutput("post-reset BLINK_MASK", bus.o_rdata, 32'h0);
    applyStimulus(0, 1, BASE + 8, 0, 0);
    checkOutput("post-reset BLINK_DIV", bus.o_rdata, 32'h0);
    checkOutput("post-reset o_led", {26'd0, o_led}, 32'h3F);

`ifdef LED_PWM_EN
    applyStimulus(1, 0, BASE, 32'h3F, 4'hF);
    applyStimulus(1, 0, BASE + 16, 32'd64, 4'hF);
    idle(1);
    litCnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (o_led == 6'h00) litCnt++;
      idle(1);
    end
    checkOutput("pwm duty64 lit cycles", 32'(litCnt), 32'd64);
    applyStimulus(1, 0, BASE + 16, 32'd0, 4'hF);
    idle(1);
    litCnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (o_led != 6'h3F) litCnt++;
      idle(1);
    end
    checkOutput("pwm duty0 lit cycles", 32'(litCnt), 32'd0);
`else
    litCnt = 0;
`endif

    for (int n = 0; n < 4000; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: addr = BASE;
        1: addr = BASE + 4;
        2: addr = BASE + 8;
        3: addr = BASE + 12;
        4: addr = BASE + 16;
        5: addr = BASE + 20;
        6: addr = BASE - 4;
        7: addr = 32'h200;
        default: addr = $urandom;
      endcase
      if (sel < 8) addr = addr | 32'($urandom_range(0, 3));
      wdata = $urandom;
      if (sel == 2 && $urandom_range(0, 15) != 0) wdata = 32'($urandom_range(0, 6));
      if (sel == 4 && $urandom_range(0, 1) == 0) wdata = 32'hFF;
      bus.i_we    = ($urandom_range(0, 3) == 0);
      bus.i_re    = ($urandom_range(0, 1) == 0);
      bus.i_addr  = addr;
      bus.i_wdata = wdata;
      bus.i_wstrb = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      idle(1);
    end
    bus.i_we = 1'b0; bus.i_re = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end
endmodule
